apb_requester: RTL and testbench

- Single-outstanding APB4 requester that converts a valid/ready command/response interface into APB transfers.
- Sits directly upstream of the APB completer and drives the requester-side signals that the APB protocol checker monitors.
- Ends every transfer with psel/penable low and one or more idle cycles, so back-to-back SETUP phases never occur.
- Includes a wait-state timeout that aborts a hung ACCESS phase.

---
 rtl/apb_requester.sv | 158 +++++++++++++++
 tb/tb_apb_requester.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// Single-outstanding APB4 requester: turns a valid/ready command into one
// SETUP/ACCESS transfer and returns the result on a valid/ready response port.
module apb_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    input  logic                    cmd_nse,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    pnse,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [SW-1:0]         strb;
        logic [2:0]            prot;
        logic                  nse;
    } apb_req_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    state_t   state_q, state_d;
    apb_req_t req_q, req_d;
    apb_rsp_t rsp_q, rsp_d;
    logic     psel_q, psel_d, pen_q, pen_d, rdy_q, rdy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic     tmo_hit;

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rsp_d   = rsp_q;
        psel_d  = psel_q;
        pen_d   = pen_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && rdy_q) begin
                    req_d.write = cmd_write;
                    req_d.addr  = cmd_addr;
                    req_d.wdata = cmd_wdata;
                    req_d.strb  = cmd_write ? cmd_strb : '0;
                    req_d.prot  = cmd_prot;
                    req_d.nse   = cmd_nse;
                    psel_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                pen_d   = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over a timeout landing in the same cycle
                if (pready) begin
                    rsp_d.valid   = 1'b1;
                    rsp_d.rdata   = req_q.write ? '0 : prdata;
                    rsp_d.err     = pslverr;
                    rsp_d.timeout = 1'b0;
                    psel_d        = 1'b0;
                    pen_d         = 1'b0;
                    state_d       = RESP;
                end else if (tmo_hit) begin
                    rsp_d.valid   = 1'b1;
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    psel_d        = 1'b0;
                    pen_d         = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_d.valid = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            req_q   <= '0;
            rsp_q   <= '0;
            psel_q  <= 1'b0;
            pen_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            psel_q  <= psel_d;
            pen_q   <= pen_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_ready   = rdy_q;
    assign psel        = psel_q;
    assign penable     = pen_q;
    assign paddr       = req_q.addr;
    assign pwrite      = req_q.write;
    assign pwdata      = req_q.wdata;
    assign pstrb       = req_q.strb;
    assign pprot       = req_q.prot;
    assign pnse        = req_q.nse;
    assign rsp_valid   = rsp_q.valid;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: vector table, randomized transfers against a
// transaction-level model, and hand sequences for backpressure and reset.
module tb_apb_requester;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_nse;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic [2:0]  pprot;
    logic        pnse, psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pclk = ~pclk;

    apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .cmd_nse(cmd_nse),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pprot(pprot), .pnse(pnse), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        nse;
        int          waits;     // pready-low ACCESS cycles before pready
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
        int          exp_acc;   // ACCESS cycles seen on the bus
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level outcome of one transfer given its completer behaviour.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_tmo   = (v.waits >= TO);
        r.exp_acc   = r.exp_tmo ? TO : v.waits + 1;
        r.exp_err   = r.exp_tmo | v.slverr;
        r.exp_rdata = (r.exp_tmo || v.wr) ? 32'h0 : v.prdata;
        return r;
    endfunction

    task automatic do_xfer(input vec_t v, input int rsp_delay);
        int t;
        int acc;
        logic [3:0] exp_strb;
        exp_strb = v.wr ? v.strb : 4'h0;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge pclk);
            t++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_strb = v.strb; cmd_prot = v.prot; cmd_nse = v.nse;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom; cmd_wdata = $urandom; cmd_strb = 4'($urandom);
        chk("setup_psel", {psel, penable, cmd_ready}, 3'b100);
        chk("setup_addr", paddr, v.addr);
        chk("setup_ctl", {pwrite, pprot, pnse, pstrb}, {v.wr, v.prot, v.nse, exp_strb});
        if (v.wr) chk("setup_wdata", pwdata, v.wdata);
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
        @(negedge pclk);
        acc = 0;
        while (psel && penable && acc < 40) begin
            chk("acc_ctl", {paddr, pwrite, pprot, pnse, pstrb, rsp_valid},
                {v.addr, v.wr, v.prot, v.nse, exp_strb, 1'b0});
            if (v.wr) chk("acc_wdata", pwdata, v.wdata);
            pready  = (acc == v.waits);
            prdata  = pready ? v.prdata : $urandom;
            pslverr = pready ? v.slverr : 1'($urandom);
            acc++;
            @(negedge pclk);
        end
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
        chk("acc_cycles", acc, v.exp_acc);
        chk("done_psel", {psel, penable}, 2'b00);
        for (int i = 0; i <= rsp_delay; i++) begin
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("rsp_flags", {rsp_err, rsp_timeout}, {v.exp_err, v.exp_tmo});
            chk("resp_idle", {psel, cmd_ready}, 2'b00);
            rsp_ready = (i == rsp_delay);
            @(negedge pclk);
        end
        rsp_ready = 1'b0;
        chk("rsp_drop", {rsp_valid, cmd_ready, psel}, 3'b010);
    endtask

    // No SETUP directly after ACCESS, and penable never without psel.
    logic prev_acc = 1'b0;
    always @(negedge pclk) begin
        if (preset) begin
            prev_acc <= 1'b0;
        end else begin
            if (penable && !psel) chk("penable_wo_psel", 1'b1, 1'b0);
            if (prev_acc && psel && !penable) chk("adjacent_psel", 1'b1, 1'b0);
            prev_acc <= psel && penable;
        end
    end

    vec_t tbl[7];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 1'b0, 0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1};
        tbl[1] = '{1'b0, 32'h20, 32'h0,        4'hF, 3'd2, 1'b0, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 4};
        tbl[2] = '{1'b1, 32'h30, 32'h01020304, 4'h5, 3'd1, 1'b1, 1, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 2};
        tbl[3] = '{1'b0, 32'h40, 32'h0,        4'h3, 3'd0, 1'b0, 9, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 1'b1, 4};
        tbl[4] = '{1'b0, 32'h44, 32'h0,        4'h0, 3'd4, 1'b0, 2, 32'hAAAA5555, 1'b1, 32'hAAAA5555, 1'b1, 1'b0, 3};
        tbl[5] = '{1'b0, 32'h48, 32'h0,        4'hF, 3'd7, 1'b1, 0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1};
        tbl[6] = '{1'b1, 32'h4C, 32'h55AA55AA, 4'h9, 3'd3, 1'b0, 3, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 4};

        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; cmd_nse = 1'b0; rsp_ready = 1'b0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (3) @(negedge pclk);
        chk("reset_outs", {cmd_ready, rsp_valid, psel, penable, pwrite, rsp_err, rsp_timeout},
            7'h00);
        chk("reset_bus", {paddr, pwdata, pstrb, pprot, pnse, rsp_rdata}, '0);
        preset = 1'b0;
        @(negedge pclk);
        chk("post_reset_ready", cmd_ready, 1'b1);

        foreach (tbl[i]) do_xfer(tbl[i], 0);

        // response backpressure followed by a queued command
        do_xfer(tbl[1], 5);
        do_xfer(tbl[0], 0);

        for (int n = 0; n < 40; n++) begin
            rv.wr = 1'($urandom); rv.addr = $urandom; rv.wdata = $urandom;
            rv.strb = 4'($urandom); rv.prot = 3'($urandom); rv.nse = 1'($urandom);
            rv.waits = $urandom_range(0, 5); rv.prdata = $urandom; rv.slverr = 1'($urandom);
            do_xfer(model(rv), $urandom_range(0, 2));
        end

        // reset in the middle of ACCESS
        while (!cmd_ready) @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_prot = 3'd0; cmd_nse = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        pready = 1'b0;
        #2 preset = 1'b1;
        #1 chk("async_reset", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        chk("reset_discard", {rsp_valid, psel, cmd_ready}, 3'b001);
        rv = '{1'b0, 32'h84, 32'h0, 4'hF, 3'd0, 1'b0, 1, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, 1'b0, 0};
        do_xfer(model(rv), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
